// File: rtl/pcihellocore_button_ctrl.sv
// pcihellocore_button_ctrl: Avalon-MM push-button PIO with press capture, press counter and irq.
// Define PCIHELLOCORE_BUTTON_DEBOUNCE_EN to build the per-bit debounce counters.
module pcihellocore_button_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] r_sync1, r_sync2, r_prev, r_mask, r_edge;
  logic [WIDTH-1:0] w_stable, w_press, w_clr;
  logic [15:0]      r_pcnt;
  logic [16:0]      w_sum;
  logic [5:0]       w_pc;
  logic             w_pcnt_clr;
  logic             w_unused;

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_param_check
    $error("pcihellocore_button_ctrl: parameter out of range");
  end

  assign w_unused = ^writedata;

`ifdef PCIHELLOCORE_BUTTON_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt [WIDTH];
  // The counter only runs while the synchronized input disagrees with the accepted level.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_stable <= '1;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (r_sync2[i] == r_stable[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  assign w_stable = r_stable;
`else
  assign w_stable = r_sync2;
`endif

  always_comb begin
    w_press    = r_prev & ~w_stable;
    w_clr      = (write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    w_pcnt_clr = write && address == 2'd3;
    w_pc       = '0;
    for (int i = 0; i < WIDTH; i++) w_pc = w_pc + 6'(w_press[i]);
    w_sum      = {1'b0, r_pcnt} + 17'(w_pc);
  end

  // New presses are OR-ed in after the W1C mask so a same-cycle set survives the clear.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_prev   <= '1;
      r_mask   <= '0;
      r_edge   <= '0;
      r_pcnt   <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= w_stable;
      if (write && address == 2'd1) r_mask <= writedata[WIDTH-1:0];
      r_edge  <= (r_edge & ~w_clr) | w_press;
      r_pcnt  <= w_pcnt_clr ? 16'h0000 : w_sum[16] ? 16'hFFFF : w_sum[15:0];
      irq     <= |(r_edge & r_mask);
      if (read)
        readdata <= address == 2'd0 ? 32'(w_stable) :
                    address == 2'd1 ? 32'(r_mask)   :
                    address == 2'd2 ? 32'(r_edge)   : 32'(r_pcnt);
    end
endmodule

// File: tb/tb_pcihellocore_button_ctrl.sv
// tb_pcihellocore_button_ctrl: directed bench for the button PIO, WIDTH=4, DEBOUNCE_CYCLES=8.
module tb_pcihellocore_button_ctrl;
  localparam int WIDTH = 4;
  localparam int DC    = 8;
`ifdef PCIHELLOCORE_BUTTON_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  // Edge on which edge_capture sets after in_port falls just past a clock edge.
  localparam int          SET_LAT     = DEB ? 11 : 3;
  localparam logic [31:0] GLITCH_EDGE = DEB ? 32'h0 : 32'h1;
  localparam logic [31:0] GLITCH_CNT  = DEB ? 32'h0 : 32'h1;
  localparam logic [31:0] PULSE_EDGE  = DEB ? 32'h0 : 32'h8;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             read, write;
  logic [31:0]      writedata, readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;
  int               checks = 0;
  int               errors = 0;

  pcihellocore_button_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    check(tag, readdata, exp);
  endtask

  task automatic press(input logic [WIDTH-1:0] m);
    in_port = ~m;
    tick(12);
    in_port = '1;
    tick(14);
  endtask

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0; in_port = '1;
    tick(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    tick(20);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    chk_rd("post_rst_level", 2'd0, 32'hF);
    chk_rd("post_rst_mask", 2'd1, 32'h0);
    chk_rd("post_rst_edge", 2'd2, 32'h0);
    chk_rd("post_rst_count", 2'd3, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    in_port = 4'hE;
    tick(5);
    in_port = 4'hF;
    tick(16);
    chk_rd("glitch_level", 2'd0, 32'hF);
    chk_rd("glitch_edge", 2'd2, GLITCH_EDGE);
    chk_rd("glitch_count", 2'd3, GLITCH_CNT);
    wr(2'd2, 32'hF);
    wr(2'd3, 32'h0);
    chk_rd("clr_edge", 2'd2, 32'h0);
    chk_rd("clr_count", 2'd3, 32'h0);

    wr(2'd1, 32'h2);
    chk_rd("mask_rd", 2'd1, 32'h2);
    press(4'h2);
    chk_rd("press1_edge", 2'd2, 32'h2);
    chk_rd("press1_count", 2'd3, 32'h1);
    check("press1_irq", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h2);
    check("irq_lag", {31'b0, irq}, 32'h1);
    tick(1);
    check("irq_clr", {31'b0, irq}, 32'h0);
    chk_rd("w1c_edge", 2'd2, 32'h0);

    address = 2'd1; writedata = 32'h5; read = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    check("rw_prewrite", readdata, 32'h2);
    chk_rd("rw_postwrite", 2'd1, 32'h5);

    in_port = 4'hB;
    tick(SET_LAT - 1);
    address = 2'd2; writedata = 32'h4; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    tick(2);
    in_port = 4'hF;
    tick(14);
    chk_rd("set_wins_edge", 2'd2, 32'h4);
    chk_rd("set_wins_count", 2'd3, 32'h2);
    check("set_wins_irq", {31'b0, irq}, 32'h1);

    wr(2'd2, 32'hF);
    force dut.r_pcnt = 16'hFFFE;
    tick(1);
    release dut.r_pcnt;
    tick(1);
    press(4'h1);
    chk_rd("sat_reach", 2'd3, 32'hFFFF);
    press(4'h1);
    chk_rd("sat_hold", 2'd3, 32'hFFFF);
    wr(2'd3, 32'h1234);
    chk_rd("count_clr", 2'd3, 32'h0);

    wr(2'd2, 32'hF);
    in_port = 4'h7;
    tick(1);
    in_port = 4'hF;
    tick(2);
    chk_rd("pulse_edge", 2'd2, PULSE_EDGE);
    tick(14);
    chk_rd("final_level", 2'd0, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcihellocore_button_ctrl.md
PCIHELLOCORE_BUTTON_CTRL -- requirements
Module: pcihellocore_button_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of push-button inputs (1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the stable-input cycle count needed to accept a new level (2..2^20).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-006 The block SHALL have port read, input, 1 bit: Avalon-MM read strobe.
REQ-007 The block SHALL have port write, input, 1 bit: Avalon-MM write strobe.
REQ-008 The block SHALL have port writedata, input, 32 bits: Avalon-MM write data.
REQ-009 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-010 The block SHALL have port in_port, input, WIDTH bits: raw, asynchronous, active-low buttons.
REQ-011 The block SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-013 Per bit, the debounce counter SHALL clear whenever the synchronized input equals the stable level; otherwise it SHALL increment.
REQ-014 On the cycle the counter reaches DEBOUNCE_CYCLES-1, the stable level SHALL take the synchronized value and the counter SHALL clear; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change the stable level.
REQ-015 A stable-level 1->0 transition (press) SHALL set that bit of edge_capture the following cycle; 0->1 transitions SHALL NOT set it.
REQ-016 Register map: addr 0 = stable level (RO); addr 1 = irq_mask (RW, WIDTH bits); addr 2 = edge_capture (read, write-1-to-clear); addr 3 = press_count (RO, 16 bits); unused upper bits SHALL read 0.
REQ-017 readdata SHALL update on the clock edge after read=1, i.e. fixed 1-cycle latency; when read=0 it SHALL hold.
REQ-018 Writes to RO addresses SHALL be ignored; writes SHALL take effect on the clock edge where write=1.
REQ-019 If a W1C clear and a new press hit the same edge_capture bit in one cycle, the set SHALL win.
REQ-020 press_count SHALL increment by the number of bits pressed in a cycle (saturating at 0xFFFF, no wrap), and SHALL clear on any write to addr 3.
REQ-021 irq SHALL be registered and equal OR-reduce(edge_capture & irq_mask) one cycle after either operand changes.
REQ-022 Simultaneous read and write SHALL return the pre-write register value.

Reset
REQ-023 While reset=1: synchronizer flops and stable level SHALL be all ones, counters 0, irq_mask 0, edge_capture 0, press_count 0, readdata 0, irq 0.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; no press SHALL be recorded as a result of reset release.

Configuration
REQ-025 Macro PCIHELLOCORE_BUTTON_DEBOUNCE_EN: when defined, REQ-013/014 debounce logic SHALL be built; when undefined, the stable level SHALL equal the synchronizer output directly (no counters, DEBOUNCE_CYCLES ignored), all else unchanged.

Verification (WIDTH=4, DEBOUNCE_CYCLES=8, macro defined unless noted)
REQ-026 Hold in_port=4'hF 20 cycles then reset -> all registers read 0 except addr 0 = 0xF, irq=0.
REQ-027 Drive in_port[0]=0 for 5 cycles then 1 -> addr 0 stays 0xF, addr 2 = 0x0, press_count=0.
REQ-028 Drive in_port[1]=0 for 12 cycles, mask=0x2 -> addr 2 = 0x2, press_count=1, irq=1; write 0x2 to addr 2 -> addr 2 = 0x0, irq=0 next cycle.
REQ-029 Press bit 2 timed so its set coincides with W1C write 0x4 to addr 2 -> addr 2 reads 0x4.
REQ-030 Force press_count to 0xFFFF via 65535 presses (or backdoor) then press once more -> stays 0xFFFF; write addr 3 -> 0x0000.
REQ-031 Macro undefined: in_port[3]=0 for 1 cycle -> addr 2 = 0x8 within 4 cycles.
